// File: rtl/jk_mod_counter_pkg.sv
// Shared constants for the modulo-N JK counter: default width and modulus,
// plus the per-bit cell control encoding used by the next-state decode.
package jk_mod_counter_pkg;

   localparam int DEF_WIDTH = 4;
   localparam int DEF_MOD   = 10;

   // What a single JK cell should do on the coming edge.
   typedef enum logic [1:0] {
      CELL_HOLD   = 2'b00,
      CELL_TOGGLE = 2'b01,
      CELL_SET    = 2'b10,
      CELL_CLEAR  = 2'b11
   } cell_ctl_e;

endpackage

// File: rtl/jk_mod_counter_jk_cell.sv
// One JK flip-flop with synchronous active-high reset to 0.
// Ports: clk, rst, j, k (inputs); q, qb (state and its complement).
module jk_cell (
   input  logic clk,
   input  logic rst,
   input  logic j,
   input  logic k,
   output logic q,
   output logic qb
);

   always_ff @(posedge clk) begin
      if (rst) begin
         q <= 1'b0;
      end else begin
         case ({j, k})
            2'b00:   q <= q;
            2'b01:   q <= 1'b0;
            2'b10:   q <= 1'b1;
            default: q <= ~q;
         endcase
      end
   end

   assign qb = ~q;

endmodule

// File: rtl/jk_mod_counter.sv
// Up/down modulo-MOD counter built from WIDTH JK cells, with parallel load,
// combinational terminal count (tc) and a registered wrap pulse.
// Ports: clk, rst (sync, active-high), en, up, load, din[WIDTH] in;
//        q[WIDTH], tc, wrap out.
module jk_mod_counter
   import jk_mod_counter_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int MOD   = DEF_MOD
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] MAX = WIDTH'(MOD - 1);

   logic [WIDTH-1:0] qb;
   logic [WIDTH-1:0] nxt;
   logic [WIDTH-1:0] ld_val;
   logic [WIDTH-1:0] j;
   logic [WIDTH-1:0] k;
   logic             zero;
   logic             at_max;
   logic             over;
   cell_ctl_e        ctl [WIDTH];

   assign zero   = &qb;
   assign at_max = (q == MAX);
   assign over   = (q > MAX);
   assign ld_val = (din > MAX) ? MAX : din;

   // Count target; an out-of-range state collapses to 0 in either direction.
   always_comb begin
      nxt = q;
      if (over) begin
         nxt = '0;
      end else if (up) begin
         nxt = at_max ? '0 : q + 1'b1;
      end else begin
         nxt = zero ? MAX : q - 1'b1;
      end
   end

   // Counting is done by toggling exactly the bits that differ from the target.
   always_comb begin
      for (int i = 0; i < WIDTH; i++) begin
         ctl[i] = CELL_HOLD;
         if (load) begin
            ctl[i] = ld_val[i] ? CELL_SET : CELL_CLEAR;
         end else if (en && (nxt[i] != q[i])) begin
            ctl[i] = CELL_TOGGLE;
         end
      end
   end

   always_comb begin
      j = '0;
      k = '0;
      for (int i = 0; i < WIDTH; i++) begin
         case (ctl[i])
            CELL_TOGGLE: begin
               j[i] = 1'b1;
               k[i] = 1'b1;
            end
            CELL_SET: begin
               j[i] = 1'b1;
               k[i] = 1'b0;
            end
            CELL_CLEAR: begin
               j[i] = 1'b0;
               k[i] = 1'b1;
            end
            default: begin
               j[i] = 1'b0;
               k[i] = 1'b0;
            end
         endcase
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      jk_cell u_cell (
         .clk (clk),
         .rst (rst),
         .j   (j[i]),
         .k   (k[i]),
         .q   (q[i]),
         .qb  (qb[i])
      );
   end

   // Gated by rst so the reset state (q=0) cannot look like a down-count end.
   assign tc = ~rst & en & ~load & ((up & at_max) | (~up & zero));

   always_ff @(posedge clk) begin
      if (rst) begin
         wrap <= 1'b0;
      end else begin
         wrap <= tc;
      end
   end

endmodule

// File: tb/tb_jk_mod_counter.sv
// Directed self-checking bench for jk_mod_counter (WIDTH=4, MOD=10).
// Inputs change 1 time unit after a rising edge; outputs are checked there.
module tb_jk_mod_counter;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       up;
   logic       load;
   logic [3:0] din;
   logic [3:0] q;
   logic       tc;
   logic       wrap;

   int vectors = 0;
   int errors  = 0;

   jk_mod_counter #(.WIDTH(4), .MOD(10)) dut (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .up   (up),
      .load (load),
      .din  (din),
      .q    (q),
      .tc   (tc),
      .wrap (wrap)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs,
                        input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_state(input string tag, input int eq, input int ew);
      check({tag, ".q"}, 8'(q), 8'(eq));
      check({tag, ".wrap"}, 8'(wrap), 8'(ew));
   endtask

   int dq [4] = '{1, 0, 9, 8};
   int dw [4] = '{0, 0, 1, 0};

   initial begin
      // reset with load pending
      rst = 1'b1; load = 1'b1; din = 4'd5; en = 1'b0; up = 1'b0;
      step();
      check_state("rst1", 0, 0);
      check("rst1.tc", 8'(tc), 8'd0);
      step();
      check_state("rst2", 0, 0);
      // q=0, up=0, en=1 would assert tc without the reset gate
      load = 1'b0; en = 1'b1; up = 1'b0;
      #1;
      check("rst_gate.tc", 8'(tc), 8'd0);
      step();
      check_state("rst3", 0, 0);

      // up-count 12 cycles
      rst = 1'b0; en = 1'b1; up = 1'b1;
      for (int n = 1; n <= 12; n++) begin
         check($sformatf("up%0d.tc", n), 8'(tc), 8'((n == 10) ? 1 : 0));
         step();
         check_state($sformatf("up%0d", n), n % 10, (n == 10) ? 1 : 0);
      end

      // load 2 then count down 4
      load = 1'b1; din = 4'd2; up = 1'b0;
      #1;
      check("ld2.tc", 8'(tc), 8'd0);
      step();
      check_state("ld2", 2, 0);
      load = 1'b0;
      for (int n = 0; n < 4; n++) begin
         check($sformatf("dn%0d.tc", n), 8'(tc), 8'((n == 2) ? 1 : 0));
         step();
         check_state($sformatf("dn%0d", n), dq[n], dw[n]);
      end

      // clamp: din=13 -> 9, load beats en
      load = 1'b1; din = 4'd13; en = 1'b1;
      step();
      check_state("clamp", 9, 0);
      load = 1'b0; en = 1'b0; up = 1'b1;
      for (int n = 0; n < 3; n++) begin
         check($sformatf("hold%0d.tc", n), 8'(tc), 8'd0);
         step();
         check_state($sformatf("hold%0d", n), 9, 0);
      end

      // load at terminal count: no carry, no wrap
      en = 1'b1; up = 1'b1; load = 1'b1; din = 4'd3;
      #1;
      check("ldtc.tc", 8'(tc), 8'd0);
      step();
      check_state("ldtc", 3, 0);

      // mid-count reset at q=6
      load = 1'b0;
      step();
      check_state("mid4", 4, 0);
      step();
      check_state("mid5", 5, 0);
      step();
      check_state("mid6", 6, 0);
      rst = 1'b1;
      step();
      check_state("midrst", 0, 0);
      rst = 1'b0;
      step();
      check_state("midrel", 1, 0);

      // direction flip at the boundary
      load = 1'b1; din = 4'd9;
      step();
      check_state("flipld", 9, 0);
      load = 1'b0; up = 1'b1;
      #1;
      check("flip_up.tc", 8'(tc), 8'd1);
      step();
      check_state("flip_up", 0, 1);
      up = 1'b0;
      #1;
      check("flip_dn.tc", 8'(tc), 8'd1);
      step();
      check_state("flip_dn", 9, 1);
      en = 1'b0;
      step();
      check_state("flip_end", 9, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/jk_mod_counter.md
JK_MOD_COUNTER -- requirements
Module: jk_mod_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, counter width in bits.
REQ-002 SHALL have parameter MOD, default 10, count modulus; legal range 2..2^WIDTH.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port en  input  1  count enable.
REQ-006 SHALL have port up  input  1  direction: 1 = up, 0 = down.
REQ-007 SHALL have port load  input  1  synchronous parallel load strobe.
REQ-008 SHALL have port din  input  WIDTH  parallel load value.
REQ-009 SHALL have port q  output  WIDTH  current count, taken directly from the JK cell outputs.
REQ-010 SHALL have port tc  output  1  terminal count, combinational.
REQ-011 SHALL have port wrap  output  1  registered one-cycle pulse following a wrap.

Function
REQ-012 SHALL apply this priority at each rising clk edge: rst, then load, then en, then hold.
REQ-013 SHALL load din into q one cycle after load is sampled high, regardless of en and up.
REQ-014 SHALL load MOD-1 into q when load is high and din >= MOD (clamp).
REQ-015 SHALL, when counting up with en=1 and load=0, advance q by 1 and step from MOD-1 to 0.
REQ-016 SHALL, when counting down with en=1 and load=0, decrement q by 1 and step from 0 to MOD-1.
REQ-017 SHALL hold q when en=0 and load=0.
REQ-018 SHALL drive tc = en & ~load & ((up & q==MOD-1) | (~up & q==0)).
REQ-019 SHALL set wrap high for exactly the one cycle after an edge at which tc was high; otherwise wrap is low.
REQ-020 SHALL implement each state bit as a JK cell with j=k=1 on a toggle, j=k=0 on a hold, and j=din_i, k=~din_i on a load; no direct D-path to q.
REQ-021 SHALL take the direction change into effect on the same edge at which the changed up value is sampled, with no extra cycle of latency.
REQ-022 SHALL not generate a carry on a load; wrap is low after any load edge.
REQ-023 SHALL, if q ever holds a value >= MOD, return q to 0 on the next enabled count edge in either direction.

Reset
REQ-024 SHALL, when rst is sampled high, set q=0 and wrap=0 on that edge, overriding load and en.
REQ-025 SHALL, when rst is asserted mid-count, abandon the count without finishing the current step; counting resumes from 0 on the first enabled edge after rst falls.
REQ-026 SHALL hold tc = 0 while rst is high, since q=0 and up=0 would otherwise assert it; tc is gated with ~rst.

Structure
REQ-027 SHALL place the WIDTH and MOD defaults in a shared constants package, together with the enumerated cell-control encoding (hold, toggle, set, clear).
REQ-028 SHALL instantiate WIDTH copies of one sub-module, jk_cell (ports clk, rst, j, k, q, qb), which holds a synchronous reset to 0.
REQ-029 SHALL place all next-state and JK-input decode in the parent module; jk_cell contains no counting logic.
REQ-030 SHALL contain no latches, and SHALL keep q and wrap as the only registered state.

Verification (WIDTH=4, MOD=10)
REQ-031 SHALL cover reset: rst=1 for 2 cycles with load=1, din=5 -> q=0, wrap=0, tc=0.
REQ-032 SHALL cover up-count: en=1, up=1 for 12 cycles from 0 -> q sequence 1..9,0,1,2; tc high while q=9; wrap high one cycle after q 9->0.
REQ-033 SHALL cover down-count: load din=2, then en=1, up=0 for 4 cycles -> q sequence 2,1,0,9,8; wrap pulses once after 0->9.
REQ-034 SHALL cover load clamp and priority: load=1, din=13, en=1 -> q=9 next cycle, wrap=0; en=0, load=0 -> q holds at 9 for 3 cycles.
REQ-035 SHALL cover mid-count reset: counting up, assert rst when q=6 -> q=0 on that edge; release rst -> q=1 on the next enabled edge.
REQ-036 SHALL cover direction flip at boundary: q=9, up=1 -> q=0; then up=0 on the next edge -> q=9, with two wrap pulses on consecutive cycles.
